// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), sync polarity codes and
// the axis-length helper used by the raster timing generator.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam bit POL_NEG = 1'b0;
  localparam bit POL_POS = 1'b1;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered sync/active decode
// computed from the next count so the flags line up with o_Count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter bit POL    = POL_NEG,
  parameter int CNT_W  = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Step,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Wrap,
  output logic             o_Sync,
  output logic             o_Active
);

  localparam int TOTAL      = total(ACTIVE, FP, SYNC, BP);
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;

  if (TOTAL > (1 << CNT_W) || SYNC < 1) begin : g_param_err
    $error("vga_axis_counter: TOTAL exceeds 2**CNT_W or SYNC is zero");
  end

  // Decode bounds carry one extra bit because SYNC_END may equal 2**CNT_W.
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   ACT_LIM  = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0]   SYNC_LO  = (CNT_W+1)'(SYNC_START);
  localparam logic [CNT_W:0]   SYNC_HI  = (CNT_W+1)'(SYNC_END);
  localparam bit               RST_ACT  = (ACTIVE > 0);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   count_ext;
  logic             sync_q, sync_d;
  logic             active_q, active_d;

  always_comb begin
    o_Wrap    = i_Step && (count_q == LAST);
    count_d   = count_q;
    if (o_Wrap) begin
      count_d = '0;
    end else if (i_Step) begin
      count_d = count_q + CNT_W'(1);
    end
    count_ext = {1'b0, count_d};
    active_d  = (count_ext < ACT_LIM);
    sync_d    = ((count_ext >= SYNC_LO) && (count_ext < SYNC_HI)) ? POL : ~POL;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      count_q  <= '0;
      sync_q   <= ~POL;
      active_q <= RST_ACT;
    end else begin
      count_q  <= count_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign o_Count  = count_q;
  assign o_Sync   = sync_q;
  assign o_Active = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal axis steps on the pixel enable, vertical
// axis steps on the horizontal wrap; line/frame strobes follow each wrap.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_COLS = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int ACTIVE_ROWS = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter bit H_POL       = POL_NEG,
  parameter bit V_POL       = POL_NEG,
  parameter int CNT_W       = 10
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Pix_En,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic             o_Line_Start,
  output logic             o_Frame_Start,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count
);

  logic h_wrap, v_wrap;
  logic h_active, v_active;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .ACTIVE (ACTIVE_COLS),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Step   (i_Pix_En),
    .o_Count  (o_Col_Count),
    .o_Wrap   (h_wrap),
    .o_Sync   (o_HSync),
    .o_Active (h_active)
  );

  vga_axis_counter #(
    .ACTIVE (ACTIVE_ROWS),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Step   (h_wrap),
    .o_Count  (o_Row_Count),
    .o_Wrap   (v_wrap),
    .o_Sync   (o_VSync),
    .o_Active (v_active)
  );

  // Wraps only occur on enabled clocks, so strobes are one clock wide by construction.
  always_comb begin
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Active      = h_active && v_active;
  assign o_Line_Start  = line_start_q;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a tiny-parameter vector table plus
// full-line, short-frame, half-rate, polarity and mid-frame reset sequences.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default 640x480 timing.
  logic       d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0] d_col, d_row;
  // Default horizontal, shortened vertical (20 active, fp 4, sync 2, bp 3 -> 29 rows).
  logic       s_hs, s_vs, s_act, s_ls, s_fs;
  logic [9:0] s_col, s_row;
  // Same as short, positive sync polarity.
  logic       p_hs, p_vs, p_act, p_ls, p_fs;
  logic [9:0] p_col, p_row;
  // Tiny: 4+0+1+1 = 6 columns, 2+0+1+1 = 4 rows, 3-bit counters.
  logic       m_hs, m_vs, m_act, m_ls, m_fs;
  logic [2:0] m_col, m_row;

  vga_timing_gen dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en),
    .o_HSync(d_hs), .o_VSync(d_vs), .o_Active(d_act),
    .o_Line_Start(d_ls), .o_Frame_Start(d_fs),
    .o_Col_Count(d_col), .o_Row_Count(d_row)
  );

  vga_timing_gen #(.ACTIVE_ROWS(20), .V_FP(4), .V_SYNC(2), .V_BP(3)) dut_short (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en),
    .o_HSync(s_hs), .o_VSync(s_vs), .o_Active(s_act),
    .o_Line_Start(s_ls), .o_Frame_Start(s_fs),
    .o_Col_Count(s_col), .o_Row_Count(s_row)
  );

  vga_timing_gen #(.ACTIVE_ROWS(20), .V_FP(4), .V_SYNC(2), .V_BP(3),
                   .H_POL(1'b1), .V_POL(1'b1)) dut_pos (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en),
    .o_HSync(p_hs), .o_VSync(p_vs), .o_Active(p_act),
    .o_Line_Start(p_ls), .o_Frame_Start(p_fs),
    .o_Col_Count(p_col), .o_Row_Count(p_row)
  );

  vga_timing_gen #(.ACTIVE_COLS(4), .H_FP(0), .H_SYNC(1), .H_BP(1),
                   .ACTIVE_ROWS(2), .V_FP(0), .V_SYNC(1), .V_BP(1), .CNT_W(3)) dut_small (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en),
    .o_HSync(m_hs), .o_VSync(m_vs), .o_Active(m_act),
    .o_Line_Start(m_ls), .o_Frame_Start(m_fs),
    .o_Col_Count(m_col), .o_Row_Count(m_row)
  );

  typedef struct {
    logic rst_n;
    logic en;
    int   col;
    int   row;
    logic hs;
    logic vs;
    logic act;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic r, input logic e, input int c, input int rw,
                              input logic hs, input logic vs, input logic a,
                              input logic ls, input logic fs);
    vec_t v;
    v.rst_n = r; v.en = e; v.col = c; v.row = rw;
    v.hs = hs; v.vs = vs; v.act = a; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic e);
    rst_n  = r;
    pix_en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  int  hs_low, hs_first_col, ls_cnt, fs_cnt, fs_bad, ls_double, hs_pulses, vs_low;
  int  pos_bad, pos_hs_high, pos_vs_high, max_col, max_row;
  logic act_639, act_640, prev_ls, prev_hs;

  initial begin
    // Tiny-parameter vectors: enable gaps, sync at col 4, wraps at col 5, mid-frame reset.
    vecs[0]  = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);
    vecs[1]  = mk(1, 1, 1, 0, 1, 1, 1, 0, 0);
    vecs[2]  = mk(1, 1, 2, 0, 1, 1, 1, 0, 0);
    vecs[3]  = mk(1, 0, 2, 0, 1, 1, 1, 0, 0);
    vecs[4]  = mk(1, 1, 3, 0, 1, 1, 1, 0, 0);
    vecs[5]  = mk(1, 1, 4, 0, 0, 1, 0, 0, 0);
    vecs[6]  = mk(1, 1, 5, 0, 1, 1, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 1, 1, 1, 1, 1, 0);
    vecs[8]  = mk(1, 0, 0, 1, 1, 1, 1, 0, 0);
    vecs[9]  = mk(1, 1, 1, 1, 1, 1, 1, 0, 0);
    vecs[10] = mk(1, 1, 2, 1, 1, 1, 1, 0, 0);
    vecs[11] = mk(1, 1, 3, 1, 1, 1, 1, 0, 0);
    vecs[12] = mk(1, 1, 4, 1, 0, 1, 0, 0, 0);
    vecs[13] = mk(1, 1, 5, 1, 1, 1, 0, 0, 0);
    vecs[14] = mk(1, 1, 0, 2, 1, 0, 0, 1, 0);
    vecs[15] = mk(1, 1, 1, 2, 1, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 0, 1, 1, 1, 0, 0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en);
      checkOutput($sformatf("vec%0d_col", i), 32'(m_col), 32'(vecs[i].col));
      checkOutput($sformatf("vec%0d_row", i), 32'(m_row), 32'(vecs[i].row));
      checkOutput($sformatf("vec%0d_hs", i),  32'(m_hs),  32'(vecs[i].hs));
      checkOutput($sformatf("vec%0d_vs", i),  32'(m_vs),  32'(vecs[i].vs));
      checkOutput($sformatf("vec%0d_act", i), 32'(m_act), 32'(vecs[i].act));
      checkOutput($sformatf("vec%0d_ls", i),  32'(m_ls),  32'(vecs[i].ls));
      checkOutput($sformatf("vec%0d_fs", i),  32'(m_fs),  32'(vecs[i].fs));
    end

    // Tiny frame wrap: 23 steps reach (5,3), the 24th returns to (0,0).
    for (int i = 0; i < 23; i++) applyStimulus(1, 1);
    checkOutput("small_last_col", 32'(m_col), 32'd5);
    checkOutput("small_last_row", 32'(m_row), 32'd3);
    checkOutput("small_last_fs", 32'(m_fs), 32'd0);
    applyStimulus(1, 1);
    checkOutput("small_wrap_col", 32'(m_col), 32'd0);
    checkOutput("small_wrap_row", 32'(m_row), 32'd0);
    checkOutput("small_wrap_fs", 32'(m_fs), 32'd1);
    checkOutput("small_wrap_ls", 32'(m_ls), 32'd1);
    checkOutput("small_wrap_act", 32'(m_act), 32'd1);
    applyStimulus(1, 0);
    checkOutput("small_hold_fs", 32'(m_fs), 32'd0);
    checkOutput("small_hold_col", 32'(m_col), 32'd0);

    // Default timing, one full line at full rate.
    applyStimulus(0, 0);
    checkOutput("def_rst_hs", 32'(d_hs), 32'd1);
    checkOutput("def_rst_vs", 32'(d_vs), 32'd1);
    hs_low = 0; hs_first_col = -1; ls_cnt = 0; act_639 = 1'b0; act_640 = 1'b1;
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1, 1);
      if (d_hs == 1'b0) begin
        hs_low++;
        if (hs_first_col < 0) hs_first_col = int'(d_col);
      end
      if (d_ls) ls_cnt++;
      if (d_col == 10'd639) act_639 = d_act;
      if (d_col == 10'd640) act_640 = d_act;
    end
    checkOutput("def_line_hs_low", 32'(hs_low), 32'd96);
    checkOutput("def_line_hs_first", 32'(hs_first_col), 32'd656);
    checkOutput("def_line_ls_cnt", 32'(ls_cnt), 32'd1);
    checkOutput("def_line_act639", 32'(act_639), 32'd1);
    checkOutput("def_line_act640", 32'(act_640), 32'd0);
    checkOutput("def_line_end_col", 32'(d_col), 32'd0);
    checkOutput("def_line_end_row", 32'(d_row), 32'd1);
    checkOutput("def_line_end_ls", 32'(d_ls), 32'd1);
    checkOutput("def_line_end_fs", 32'(d_fs), 32'd0);

    // Short frame (800 x 29) at full rate, plus the positive-polarity twin.
    applyStimulus(0, 1);
    ls_cnt = 0; fs_cnt = 0; fs_bad = 0; ls_double = 0; hs_pulses = 0; hs_low = 0; vs_low = 0;
    pos_bad = 0; pos_hs_high = 0; pos_vs_high = 0; max_col = 0; max_row = 0;
    act_639 = 1'b0; act_640 = 1'b1; prev_ls = 1'b0; prev_hs = 1'b1;
    for (int i = 0; i < 800 * 29; i++) begin
      applyStimulus(1, 1);
      if (s_ls) ls_cnt++;
      if (s_ls && prev_ls) ls_double++;
      if (s_fs) begin
        fs_cnt++;
        if (s_col != 10'd0 || s_row != 10'd0) fs_bad++;
      end
      if (!s_hs) hs_low++;
      if (!s_hs && prev_hs) hs_pulses++;
      if (!s_vs) vs_low++;
      if (p_hs) pos_hs_high++;
      if (p_vs) pos_vs_high++;
      if (p_hs !== (p_col >= 10'd656 && p_col < 10'd752)) pos_bad++;
      if (p_vs !== (p_row >= 10'd24 && p_row < 10'd26)) pos_bad++;
      if (int'(s_col) > max_col) max_col = int'(s_col);
      if (int'(s_row) > max_row) max_row = int'(s_row);
      if (s_row == 10'd19 && s_col == 10'd639) act_639 = s_act;
      if (s_row == 10'd19 && s_col == 10'd640) act_640 = s_act;
      if (i == 800 * 29 - 2) begin
        checkOutput("frame_pre_col", 32'(s_col), 32'd799);
        checkOutput("frame_pre_row", 32'(s_row), 32'd28);
      end
      prev_ls = s_ls;
      prev_hs = s_hs;
    end
    checkOutput("frame_ls_cnt", 32'(ls_cnt), 32'd29);
    checkOutput("frame_ls_width", 32'(ls_double), 32'd0);
    checkOutput("frame_fs_cnt", 32'(fs_cnt), 32'd1);
    checkOutput("frame_fs_pos", 32'(fs_bad), 32'd0);
    checkOutput("frame_hs_pulses", 32'(hs_pulses), 32'd29);
    checkOutput("frame_hs_low", 32'(hs_low), 32'd2784);
    checkOutput("frame_vs_low", 32'(vs_low), 32'd1600);
    checkOutput("frame_max_col", 32'(max_col), 32'd799);
    checkOutput("frame_max_row", 32'(max_row), 32'd28);
    checkOutput("frame_act639_r19", 32'(act_639), 32'd1);
    checkOutput("frame_act640_r19", 32'(act_640), 32'd0);
    checkOutput("frame_end_fs", 32'(s_fs), 32'd1);
    checkOutput("frame_end_ls", 32'(s_ls), 32'd1);
    checkOutput("frame_end_act", 32'(s_act), 32'd1);
    checkOutput("pos_decode_bad", 32'(pos_bad), 32'd0);
    checkOutput("pos_hs_high", 32'(pos_hs_high), 32'd2784);
    checkOutput("pos_vs_high", 32'(pos_vs_high), 32'd1600);

    // Mid-frame reset while both syncs are asserted (col 700, row 25).
    for (int i = 0; i < 25 * 800 + 700; i++) applyStimulus(1, 1);
    checkOutput("midrst_pre_col", 32'(s_col), 32'd700);
    checkOutput("midrst_pre_row", 32'(s_row), 32'd25);
    checkOutput("midrst_pre_hs", 32'(s_hs), 32'd0);
    checkOutput("midrst_pre_vs", 32'(s_vs), 32'd0);
    applyStimulus(0, 1);
    checkOutput("midrst_col", 32'(s_col), 32'd0);
    checkOutput("midrst_row", 32'(s_row), 32'd0);
    checkOutput("midrst_hs", 32'(s_hs), 32'd1);
    checkOutput("midrst_vs", 32'(s_vs), 32'd1);
    checkOutput("midrst_act", 32'(s_act), 32'd1);
    checkOutput("midrst_fs", 32'(s_fs), 32'd0);
    checkOutput("midrst_pos_hs", 32'(p_hs), 32'd0);
    checkOutput("midrst_pos_vs", 32'(p_vs), 32'd0);

    // Half-rate enable: one line takes 1600 clocks.
    hs_low = 0; ls_cnt = 0; ls_double = 0; prev_ls = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      applyStimulus(1, (i % 2) == 0);
      if (!d_hs) hs_low++;
      if (d_ls) ls_cnt++;
      if (d_ls && prev_ls) ls_double++;
      prev_ls = d_ls;
      if (i == 9) checkOutput("half_col_at10", 32'(d_col), 32'd5);
    end
    checkOutput("half_hs_low", 32'(hs_low), 32'd192);
    checkOutput("half_ls_cnt", 32'(ls_cnt), 32'd1);
    checkOutput("half_ls_width", 32'(ls_double), 32'd0);
    checkOutput("half_end_col", 32'(d_col), 32'd0);
    checkOutput("half_end_row", 32'(d_row), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
